// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 host transmitter
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_WAIT_IDLE,
    ST_ERR
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESEND  = 8'hFE;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;

  localparam int PS2_FRAME_LEN = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 pin synchroniser, agreement filter and falling-edge pulse
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic [1:0]     sync_q;
  logic [FCW-1:0] agree_q;
  logic           filt_q;
  logic           filt_prev_q;

  // Filtered value only flips after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      agree_q     <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      sync_q      <= {sync_q[0], raw_i};
      filt_prev_q <= filt_q;
      if (sync_q[1] == filt_q) begin
        agree_q <= '0;
      end else if (agree_q == FCW'(FILTER_LEN - 1)) begin
        filt_q  <= sync_q[1];
        agree_q <= '0;
      end else begin
        agree_q <= agree_q + 1'b1;
      end
    end
  end

  assign filt_o = filt_q;
  assign fall_o = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int          FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int          CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);

  ps2_tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic          drive_q, drive_d;
  logic          clk_filt, clk_fall, data_filt, data_fall_unused;
  logic          timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst(rst), .raw_i(ps2_clk_in), .filt_o(clk_filt), .fall_o(clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .rst(rst), .raw_i(ps2_data_in), .filt_o(data_filt), .fall_o(data_fall_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      drive_q   <= drive_d;
    end
  end

  // One counter serves the inhibit hold and, from RTS on, the ACK timeout.
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  assign timeout = (cnt_q >= TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    parity_d    = parity_q;
    drive_d     = drive_q;
    tx_ready    = 1'b0;
    tx_busy     = 1'b1;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_ready = 1'b1;
        tx_busy  = 1'b0;
        if (tx_valid) begin
          data_d   = tx_data;
          parity_d = odd_parity(tx_data);
          cnt_d    = '0;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        cnt_d      = cnt_inc;
        if (cnt_q == INH_LAST) begin
          ps2_data_oe = 1'b1;
          cnt_d       = '0;
          state_d     = ST_RTS;
        end
      end
      ST_RTS: begin
        ps2_data_oe = 1'b1;
        bit_cnt_d   = '0;
        drive_d     = 1'b1;
        cnt_d       = cnt_inc;
        state_d     = timeout ? ST_ERR : ST_SHIFT;
      end
      ST_SHIFT: begin
        ps2_data_oe = drive_q;
        cnt_d       = cnt_inc;
        if (timeout) begin
          state_d = ST_ERR;
        end else if (clk_fall) begin
          // bit_cnt_q holds the number of falls seen before this one.
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            drive_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            drive_d = ~parity_q;
          end else if (bit_cnt_q == 4'd9) begin
            drive_d = 1'b0;
          end else begin
            state_d = data_filt ? ST_ERR : ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          state_d = ST_ERR;
        end else if (clk_filt && data_filt) begin
          tx_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        tx_err  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      tx_done = 1'b0;
      tx_err  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 40;
  localparam int TO   = 3000;
  localparam int FL   = 4;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int ncmp = 0;
  int nfail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int ready_cnt = 0;
  int low_run = 0;
  int last_low = 0;

  always #5 clk = ~clk;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (tx_ready) ready_cnt <= ready_cnt + 1;
    if (ps2_clk_oe) begin
      low_run <= low_run + 1;
    end else if (low_run != 0) begin
      last_low <= low_run;
      low_run  <= 0;
    end
  end

  // Expected wire image: 8 data bits LSB first, odd parity, stop bit.
  function automatic logic [9:0] wire_bits(input logic [7:0] b);
    logic p;
    p = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, p, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    k = 0;
    while (!tx_ready && k < 5000) begin cyc(1); k++; end
    check("ready_before_send", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    check("ready_drops", tx_ready, 0);
    tx_data = 8'($urandom);
  endtask

  task automatic dev(input int nfalls, input bit nack, input int glitch_at, input int inj_at,
                     output logic [9:0] got, output bit start_ok);
    int k;
    k = 0;
    got = '0;
    start_ok = 1'b0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && k < INH + 200) begin cyc(1); k++; end
    check("rts_seen", {31'd0, ps2_data_oe & ~ps2_clk_oe}, 1);
    if (nfalls == 0) return;
    cyc(HALF);
    start_ok = (ps2_data_in == 1'b0);
    for (int i = 1; i <= nfalls; i++) begin
      if (i == PS2_FRAME_LEN) begin dev_data = nack; cyc(HALF); end
      dev_clk = 1'b0;
      cyc(HALF);
      if (i <= 10) got[i-1] = ps2_data_in;
      if (i == inj_at) begin tx_valid = 1'b1; tx_data = 8'h55; end
      dev_clk = 1'b1;
      if (i == glitch_at) begin
        cyc(5); dev_clk = 1'b0; cyc(2); dev_clk = 1'b1; cyc(HALF - 7);
      end else begin
        cyc(HALF);
      end
    end
    dev_data = 1'b1;
    tx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b, input bit nack, input int glitch_at, input int inj_at);
    logic [9:0] got;
    bit st;
    int d0, e0, r0, k;
    d0 = done_cnt;
    e0 = err_cnt;
    send(b);
    r0 = ready_cnt;
    dev(PS2_FRAME_LEN, nack, glitch_at, inj_at, got, st);
    k = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < 500) begin cyc(1); k++; end
    check("end_seen", {31'd0, (done_cnt != d0) || (err_cnt != e0)}, 1);
    check("inhibit_len", last_low, INH);
    check("start_bit", {31'd0, st}, 1);
    check("wire_bits", {22'd0, got}, {22'd0, wire_bits(b)});
    if (!nack) check("ready_low_in_frame", ready_cnt - r0, 0);
    cyc(3);
    check("done_pulses", done_cnt - d0, nack ? 0 : 1);
    check("err_pulses", err_cnt - e0, nack ? 1 : 0);
  endtask

  initial begin
    logic [9:0] got;
    bit st;
    int d0, e0, k;

    cyc(3);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    rst = 1'b0;
    cyc(2);

    frame(PS2_CMD_SET_LED, 1'b0, 0, 0);
    frame(8'h01, 1'b0, 0, 0);
    frame(PS2_CMD_RESET, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) frame(8'($urandom), 1'b0, 0, 0);

    // Device never clocks: timeout measured from RTS entry.
    e0 = err_cnt;
    send(8'($urandom));
    dev(0, 1'b0, 0, 0, got, st);
    k = 0;
    while (!tx_err && k < TO + 20) begin cyc(1); k++; end
    check("timeout_cycles", k, TO);
    cyc(1);
    check("to_clk_oe", ps2_clk_oe, 0);
    check("to_data_oe", ps2_data_oe, 0);
    check("to_ready", tx_ready, 1);
    check("to_err_count", err_cnt - e0, 1);

    frame(8'($urandom), 1'b1, 0, 0);
    frame(PS2_CMD_RESEND, 1'b0, 0, 0);
    frame(PS2_CMD_ENABLE, 1'b0, 0, 3);
    frame(8'hA5, 1'b0, 5, 0);

    // Reset in the middle of a frame.
    d0 = done_cnt;
    e0 = err_cnt;
    send(PS2_CMD_SET_LED);
    dev(4, 1'b0, 0, 0, got, st);
    check("mid_bits", {28'd0, got[3:0]}, {28'd0, wire_bits(PS2_CMD_SET_LED) & 10'h00F});
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_mid_clk_oe", ps2_clk_oe, 0);
    check("rst_mid_data_oe", ps2_data_oe, 0);
    cyc(20);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_no_err", err_cnt - e0, 0);
    frame(PS2_CMD_ENABLE, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
